// File: rtl/uart_fifo_core.sv
`default_nettype none
// ============================================================================
// Module  : uart_fifo_core
// Purpose : Full-duplex UART with a TX FIFO and an RX FIFO behind a
//           strobe-based byte interface. The data width, FIFO depth, parity
//           mode and stop-bit count are all parameters. Each received word
//           carries its own parity and framing error flags.
// Ports   : clk      - system clock, rising edge
//           rst      - asynchronous reset, active low
//           denv/wr  - word to transmit / push strobe into the TX FIFO
//           drec/rd  - RX FIFO head (first-word fall-through) / pop strobe
//           par_err  - parity error flag of the head word
//           frm_err  - framing error flag of the head word
//           rx_empty - RX FIFO empty
//           rx_ovf   - sticky RX overflow flag, cleared by clr_ovf
//           tx_full  - TX FIFO full
//           tx_busy  - TX FIFO holds data, or a frame is being sent
//           txd/rxd  - serial pins, idle high
// Revision: 1.0 - initial release
// ============================================================================
module uart_fifo_core #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] denv,
  input  logic              wr,
  output logic [DATA_W-1:0] drec,
  input  logic              rd,
  output logic              par_err,
  output logic              frm_err,
  output logic              rx_empty,
  output logic              rx_ovf,
  input  logic              clr_ovf,
  output logic              tx_full,
  output logic              tx_busy,
  output logic              txd,
  input  logic              rxd
);

  localparam int DIV       = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF      = DIV / 2;
  localparam int STOP_CLKS = STOP_BITS * DIV;
  localparam int CNT_W     = $clog2(STOP_CLKS + 1);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int PW        = AW + 1;
  localparam int RXW       = DATA_W + 2;
  localparam int BIT_W     = $clog2(DATA_W);

  localparam logic             PAR_EN    = (PARITY != 0);
  localparam logic             PAR_ODD   = (PARITY == 2);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [PW-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic              tx_empty, tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  // tx_full comes from the registered pointers, so a pop in this same cycle
  // cannot make room for a write in this cycle.
  assign tx_push  = wr && !tx_full;
  assign tx_head  = tx_mem_q[tx_rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= denv;
  end

  // --------------------------------------------------------------------------
  // TX FSM. txd is registered from the current state, so the line lags the
  // state by one clock. That lag is the same at the start and end of every
  // bit, so bit lengths are exact.
  // --------------------------------------------------------------------------
  state_t            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shr_q, tx_shr_d;
  logic              tx_par_q, tx_par_d;
  logic              txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shr_d   = tx_shr_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    txd_d      = 1'b1;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shr_d   = tx_head;
          tx_par_d   = (^tx_head) ^ PAR_ODD;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        txd_d = tx_shr_q[0];
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d = '0;
          tx_shr_d = tx_shr_q >> 1;
          if (tx_bit_q == BIT_LAST) tx_state_d = PAR_EN ? S_PAR : S_STOP;
          else                      tx_bit_d   = tx_bit_q + BIT_W'(1);
        end
      end
      S_PAR: begin
        txd_d = tx_par_q;
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == STOP_LAST) begin
          tx_cnt_d = '0;
          // Chain straight into the next frame so that no idle gap appears.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shr_d   = tx_head;
            tx_par_d   = (^tx_head) ^ PAR_ODD;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + PW'(1);
    if (tx_pop)  tx_rptr_d = tx_rptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shr_q   <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shr_q   <= tx_shr_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = !tx_empty || (tx_state_q != S_IDLE);

  // --------------------------------------------------------------------------
  // RX front end: two-flop synchronizer plus one delay stage that is used
  // for falling-edge detection.
  // --------------------------------------------------------------------------
  logic rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= rxd;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

  // Only a high-to-low transition arms the receiver. After a framing error
  // the line can stay low, and then nothing re-arms the receiver until the
  // line goes high again.
  assign rx_fall = rx_prev_q && !rx_sync2_q;

  // --------------------------------------------------------------------------
  // RX FSM
  // --------------------------------------------------------------------------
  state_t            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shr_q, rx_shr_d;
  logic              rx_perr_q, rx_perr_d;
  logic              rx_req;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shr_d   = rx_shr_q;
    rx_perr_d  = rx_perr_q;
    rx_req     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync2_q) begin
            rx_state_d = S_IDLE;          // the line was high again: a glitch
          end else begin
            rx_bit_d   = '0;
            rx_perr_d  = 1'b0;
            rx_state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d = '0;
          rx_shr_d = {rx_sync2_q, rx_shr_q[DATA_W-1:1]};
          if (rx_bit_q == BIT_LAST) rx_state_d = PAR_EN ? S_PAR : S_STOP;
          else                      rx_bit_d   = rx_bit_q + BIT_W'(1);
        end
      end
      S_PAR: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_perr_d  = rx_sync2_q ^ (^rx_shr_q) ^ PAR_ODD;
          rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_req     = 1'b1;
          rx_state_d = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // RX FIFO. Each entry is {frm_err, par_err, data}.
  // --------------------------------------------------------------------------
  logic [RXW-1:0] rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RXW-1:0] rx_hold_q, rx_hold_d;
  logic [RXW-1:0] rx_entry, rx_out;
  logic           rx_full, rx_pop, rx_push;
  logic           rx_ovf_q, rx_ovf_d;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign rx_pop   = rd && !rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  // the word.
  assign rx_push  = rx_req && (!rx_full || rx_pop);
  assign rx_entry = {~rx_sync2_q, rx_perr_q, rx_shr_q};

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_entry;
  end

  // While the FIFO is empty the outputs show the last head seen (all zero
  // after reset). The memory itself is never reset.
  always_comb begin
    rx_out    = rx_empty ? rx_hold_q : rx_mem_q[rx_rptr_q[AW-1:0]];
    rx_hold_d = rx_out;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_ovf_d  = rx_ovf_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + PW'(1);
    if (rx_pop)  rx_rptr_d = rx_rptr_q + PW'(1);
    // If a clear and a new drop happen in the same cycle, the drop wins.
    if (rx_req && !rx_push) rx_ovf_d = 1'b1;
    else if (clr_ovf)       rx_ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shr_q   <= '0;
      rx_perr_q  <= 1'b0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_hold_q  <= '0;
      rx_ovf_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shr_q   <= rx_shr_d;
      rx_perr_q  <= rx_perr_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_hold_q  <= rx_hold_d;
      rx_ovf_q   <= rx_ovf_d;
    end
  end

  assign drec    = rx_out[DATA_W-1:0];
  assign par_err = rx_out[DATA_W];
  assign frm_err = rx_out[DATA_W+1];
  assign rx_ovf  = rx_ovf_q;

endmodule
`default_nettype wire

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
- Parametrised full-duplex UART with a TX FIFO and an RX FIFO behind a strobe-based byte interface (denv/wr, drec/rd).
- Successor to the fixed 8N1 single-register echo UART: adds configurable data width, FIFO depth, parity mode, stop-bit count and per-word error status.
- Sits between the system core and the board serial pins.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- baud, 115200, line rate in bit/s. Bit period DIV = (clk_freq + baud/2) / baud clocks. DIV must be >= 4.
- data_w, 8, data bits per frame, range 5..9.
- fifo_depth, 16, entries per FIFO. Must be a power of 2, >= 2.
- parity, 0, parity mode: 0 none, 1 even, 2 odd.
- stop_bits, 1, number of stop bits transmitted: 1 or 2. The receiver checks the first stop bit only.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- denv  in  data_w  word to transmit.
- wr  in  1  one-cycle strobe that pushes denv into the TX FIFO.
- drec  out  data_w  head of the RX FIFO (first-word fall-through).
- rd  in  1  one-cycle strobe that pops the RX FIFO head.
- par_err  out  1  parity error flag of the head word.
- frm_err  out  1  framing error flag of the head word.
- rx_empty  out  1  RX FIFO empty.
- rx_ovf  out  1  sticky: a received word was dropped because the RX FIFO was full.
- clr_ovf  in  1  clears rx_ovf.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  TX FIFO not empty or a frame is in progress.
- txd  out  1  serial output, idle high.
- rxd  in  1  serial input, asynchronous.

Behaviour:
- Reset values (rst low, asynchronous): txd=1, drec=0, par_err=0, frm_err=0, rx_empty=1, rx_ovf=0, tx_full=0, tx_busy=0. Both FIFOs are emptied, both FSMs return to IDLE, and baud counters clear. A reset mid-frame aborts the frame; txd returns to 1 immediately.
- FIFOs: circular buffers with pointers of log2(fifo_depth)+1 bits.
  - Full when the pointer MSBs differ and the low bits are equal.
  - Wrap-around is natural overflow of the pointers.
- TX push:
  - wr while tx_full=0: denv is written; tx_full updates the next cycle.
  - wr while tx_full=1: the write is ignored, FIFO contents unchanged.
- RX pop:
  - rd while rx_empty=0: advances the head; drec, par_err and frm_err show the next entry the following cycle.
  - rd while empty: ignored; outputs hold.
  - When rx_empty=1, drec holds its last value.
- RX FIFO entry is data_w+2 bits: {frm_err, par_err, data}.
- TX FSM: IDLE -> START -> DATA -> PAR -> STOP -> IDLE.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: txd=0 for DIV clocks.
  - DATA: data_w bits, LSB first, DIV clocks each.
  - PAR: present only if parity != 0. Even: XOR of the data bits. Odd: its inverse.
  - STOP: txd=1 for stop_bits*DIV clocks.
  - Back-to-back frames: START of the next frame follows the last STOP clock with no idle gap.
  - First txd falling edge occurs 2 clocks after a wr into an empty, idle transmitter.
- RX front end: rxd passes a 2-flop synchronizer.
- RX FSM: IDLE -> START -> DATA -> PAR -> STOP -> IDLE.
  - IDLE: a synchronized high->low transition starts the counter.
  - START: sample at DIV/2. If the line is high, treat it as a glitch and return to IDLE with no word stored.
  - Data, parity and stop bits are each sampled DIV clocks after the previous sample.
  - par_err = the received parity bit mismatches the selected mode (always 0 when parity=0).
  - frm_err = the stop sample is 0.
  - At the stop sample the word plus flags is pushed. If the RX FIFO is full, the word is dropped and rx_ovf sets.
  - After a framing error, the FSM waits for rxd=1 before re-arming.
- Simultaneous events:
  - rd and an RX push in the same cycle on a full FIFO: the pop takes effect and the push succeeds, so there is no overflow.
  - wr and a TX pop in the same cycle on a full FIFO: the write is still rejected, because tx_full is evaluated before the pop.
  - clr_ovf and a new overflow in the same cycle: rx_ovf stays 1.
- Arithmetic: baud counter width is clog2(stop_bits*DIV+1). Parity is computed over data_w bits only.

Test Plan:
- Setup for all scenarios: clk_freq=1000000, baud=100000 (DIV=10), data_w=8, fifo_depth=4, txd looped to rxd unless stated.
- Reset: rst=0 for 80 ns, then release -> all outputs at their reset values, txd=1 throughout.
- Echo, parity=0: write 5, 10, 15, 255 with one-cycle wr strobes -> txd frames are contiguous, 10 bits x 10 clocks each. Then rx_empty=0, and four rd pops return drec=5, 10, 15, 255 in order, par_err=frm_err=0. rx_empty=1 after the 4th pop.
- TX full: six wr strobes of 0x01..0x06 within 6 cycles -> tx_full=1 after 4 entries are queued. The 6th write is ignored. 0x01..0x05 are received: the first is popped immediately, leaving room for 0x05. 0x06 is never transmitted.
- RX overflow: loopback with no rd, send 5 words -> rx_ovf=1 and the FIFO holds the first 4. clr_ovf pulse -> rx_ovf=0.
- Parity and framing, loopback disconnected:
  - parity=1, bench drives 0x07 with parity bit 0 -> head par_err=1, data=0x07.
  - Drive a frame with stop bit 0 -> frm_err=1. The receiver re-arms only after rxd returns high.
- Glitch and reset mid-frame:
  - 3-clock low pulse on rxd -> no word stored, rx_empty stays 1.
  - Assert rst during TX DATA bit 3 -> txd=1 immediately, tx_busy=0, and the FIFO is empty after release.
